sha256_iter_core: RTL



---
 rtl/sha256_pkg.sv | 84 ++++++++
 rtl/sha256_round_comb.sv | 41 ++++
 rtl/sha256_iter_core.sv | 115 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants and helpers for the iterative SHA-256 core.
//   K       : the 64 SHA-256 round constants
//   H0      : the standard initial hash value, word j (a..h) at [32j+31:32j]
//   core_state_t : FSM encoding of sha256_iter_core
//   bsig0/bsig1/ssig0/ssig1/ch/maj : the SHA-256 logical functions
//   idx     : LSB position of 32-bit word j inside a packed word vector
//   add8    : word-wise (no carry between words) add of two 8-word states
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } core_state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Word a sits in the low 32 bits, word h in the top 32 bits.
    localparam logic [255:0] H0 = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    function automatic int idx(input int j);
        return 32 * j;
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            r[idx(j) +: 32] = x[idx(j) +: 32] + y[idx(j) +: 32];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// sha256_round_comb: one purely combinational SHA-256 round.
//   state       in  : working state a..h, word j at [32j+31:32j]
//   window      in  : message schedule W[t..t+15], W[t] in word 0
//   k           in  : round constant K[t]
//   state_next  out : working state after round t
//   window_next out : W[t+1..t+16], window shifted down by one word
module sha256_round_comb
    import sha256_pkg::*;
(
    input  logic [255:0] state,
    input  logic [511:0] window,
    input  logic [31:0]  k,
    output logic [255:0] state_next,
    output logic [511:0] window_next
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2, w_new;

    always_comb begin
        a = state[idx(0) +: 32];
        b = state[idx(1) +: 32];
        c = state[idx(2) +: 32];
        d = state[idx(3) +: 32];
        e = state[idx(4) +: 32];
        f = state[idx(5) +: 32];
        g = state[idx(6) +: 32];
        h = state[idx(7) +: 32];

        t1 = h + bsig1(e) + ch(e, f, g) + k + window[idx(0) +: 32];
        t2 = bsig0(a) + maj(a, b, c);
        state_next = {g, f, e, d + t1, c, b, a, t1 + t2};

        // W[t+16] from words 14, 9, 1, 0 of the current window. Words produced
        // past round 63 are never consumed, so no guard is needed.
        w_new = ssig1(window[idx(14) +: 32]) + window[idx(9) +: 32]
              + ssig0(window[idx(1) +: 32]) + window[idx(0) +: 32];
        window_next = {w_new, window[511:32]};
    end

endmodule

// File: rtl/sha256_iter_core.sv
// sha256_iter_core: iterative SHA-256 compression of one 512-bit block,
// UNROLL rounds per clock, 64/UNROLL run cycles per job.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : job handshake; in_state, in_block, in_tag are the job
//   out_valid/out_ready : result handshake; out_hash = in_state + final state,
//                         out_tag = tag of that job
//
// Handshake rule (both sides): a transfer happens on a rising edge where valid
// and ready are both 1. A producer holds valid and its payload until that edge;
// the core holds out_valid/out_hash/out_tag stable while out_ready is 0, and
// in_ready never depends on in_valid.
module sha256_iter_core
    import sha256_pkg::*;
#(
    parameter int UNROLL = 4,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [255:0]      in_state,
    input  logic [511:0]      in_block,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [255:0]      out_hash,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int N = 64 / UNROLL;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 ||
          UNROLL == 16 || UNROLL == 32 || UNROLL == 64)) begin : g_bad_unroll
        $error("sha256_iter_core: UNROLL must be one of 1,2,4,8,16,32,64");
    end

    core_state_t       state_q, state_d;
    logic [5:0]        cnt;
    logic [255:0]      work, feed;
    logic [511:0]      win;
    logic [TAG_W-1:0]  tag_q;
    logic              accept, last;

    logic [255:0] chain_s [UNROLL+1];
    logic [511:0] chain_w [UNROLL+1];

    assign chain_s[0] = work;
    assign chain_w[0] = win;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [31:0] k_u;
        // r = cnt*UNROLL never exceeds 64-UNROLL, so the index stays in 0..63.
        assign k_u = K[6'(int'(cnt) * UNROLL + u)];
        sha256_round_comb u_round (
            .state       (chain_s[u]),
            .window      (chain_w[u]),
            .k           (k_u),
            .state_next  (chain_s[u+1]),
            .window_next (chain_w[u+1])
        );
    end

    always_comb begin
        state_d  = state_q;
        in_ready = !rst && (state_q == ST_IDLE || (state_q == ST_DONE && out_ready));
        accept   = in_valid && in_ready;
        last     = (state_q == ST_RUN) && (cnt == 6'(N - 1));
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            work      <= '0;
            feed      <= '0;
            win       <= '0;
            tag_q     <= '0;
            out_valid <= 1'b0;
            out_hash  <= '0;
            out_tag   <= '0;
        end else begin
            if (accept) begin
                work  <= in_state;
                feed  <= in_state;
                win   <= in_block;
                tag_q <= in_tag;
                cnt   <= '0;
            end else if (state_q == ST_RUN) begin
                work <= chain_s[UNROLL];
                win  <= chain_w[UNROLL];
                cnt  <= last ? 6'd0 : cnt + 6'd1;
            end

            if (last) begin
                out_hash  <= add8(feed, chain_s[UNROLL]);
                out_tag   <= tag_q;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
